// File: rtl/adventure_pkg.sv
// Shared room codes, direction indices and map table for the adventure room controller.
package adventure_pkg;

  typedef enum logic [2:0] {
    CAVE   = 3'd0,
    TUNNEL = 3'd1,
    RIVER  = 3'd2,
    STASH  = 3'd3,
    DEN    = 3'd4,
    VAULT  = 3'd5,
    GRAVE  = 3'd6
  } room_t;

  // Bit positions of each button inside the one-hot direction vector.
  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  // Unused encoding; the room register recovers from it to CAVE.
  localparam logic [2:0] ROOM_ILLEGAL = 3'd7;

  // Destination of a one-hot move from a walkable room; returns the same
  // room when the direction leads nowhere.
  function automatic room_t map_step(input room_t r, input logic [3:0] dir);
    room_t dest;
    dest = r;
    case (r)
      CAVE: begin
        if (dir[DIR_E]) dest = TUNNEL;
      end
      TUNNEL: begin
        if (dir[DIR_W]) dest = CAVE;
        else if (dir[DIR_S]) dest = RIVER;
      end
      RIVER: begin
        if (dir[DIR_N]) dest = TUNNEL;
        else if (dir[DIR_W]) dest = STASH;
        else if (dir[DIR_E]) dest = DEN;
      end
      STASH: begin
        if (dir[DIR_E]) dest = RIVER;
      end
      default: dest = r;
    endcase
    return dest;
  endfunction

endpackage

// File: rtl/adventure_room_fsm_dir_qualify.sv
// Button qualifier: turns level buttons into single-cycle one-hot move strobes.
//
// Handshake: accept is a valid-only strobe (no ready). When accept=1, dir holds
// exactly one set bit for that cycle only and the consumer must take it then;
// dir is all-zero whenever accept=0.
module dir_qualify
  import adventure_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       n,
  input  logic       s,
  input  logic       e,
  input  logic       w,
  output logic [3:0] dir,
  output logic       accept
);

  logic       armed_q;
  logic [3:0] btn;
  logic       idle;
  logic       one_hot;

  // Gather buttons and decide whether this cycle carries a valid move.
  always_comb begin
    btn         = 4'b0000;
    btn[DIR_N]  = n;
    btn[DIR_S]  = s;
    btn[DIR_E]  = e;
    btn[DIR_W]  = w;
    idle        = (btn == 4'b0000);
    one_hot     = !idle && ((btn & 4'(btn - 4'd1)) == 4'b0000);
    accept      = armed_q && one_hot;
    dir         = accept ? btn : 4'b0000;
  end

  // Arm on an all-released cycle; disarm once a move is taken so a held button counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
    end else if (accept) begin
      armed_q <= 1'b0;
    end else if (idle) begin
      armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/adventure_room_fsm.sv
// Room-navigation controller: walks the map, counts moves, resolves the dragon.
module adventure_room_fsm
  import adventure_pkg::*;
#(
  parameter int MOVE_W    = 8,
  parameter int MAX_MOVES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n,
  input  logic              s,
  input  logic              e,
  input  logic              w,
  input  logic              v,
  output logic              sw,
  output logic              win,
  output logic              dead,
  output logic [2:0]        room,
  output logic [MOVE_W-1:0] moves
);

  localparam bit                BUDGET_ON = (MAX_MOVES != 0);
  localparam logic [MOVE_W-1:0] BUDGET    = MOVE_W'(MAX_MOVES);
  localparam logic [MOVE_W-1:0] MOVES_MAX = '1;

  room_t             room_q, room_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic [3:0]        dir;
  logic              accept;
  room_t             dest;

  dir_qualify u_dir_qualify (
    .clk    (clk),
    .reset  (reset),
    .n      (n),
    .s      (s),
    .e      (e),
    .w      (w),
    .dir    (dir),
    .accept (accept)
  );

  // Room and move-counter registers; the room register is the FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      room_q  <= CAVE;
      moves_q <= '0;
    end else begin
      room_q  <= room_d;
      moves_q <= moves_d;
    end
  end

  // Next room and move count: terminal rooms freeze, DEN resolves on the sword,
  // the budget overrides buttons, and only room-changing moves are counted.
  always_comb begin
    room_d  = room_q;
    moves_d = moves_q;
    dest    = map_step(room_q, dir);
    case (room_q)
      VAULT, GRAVE: begin
        room_d = room_q;
      end
      DEN: begin
        room_d = v ? VAULT : GRAVE;
      end
      CAVE, TUNNEL, RIVER, STASH: begin
        if (BUDGET_ON && (moves_q == BUDGET)) begin
          room_d = GRAVE;
        end else if (accept && (dest != room_q)) begin
          room_d = dest;
          if (moves_q != MOVES_MAX) moves_d = moves_q + MOVE_W'(1);
        end
      end
      default: begin
        room_d = CAVE;
      end
    endcase
  end

  // Moore outputs decoded straight from the room register.
  always_comb begin
    room  = room_q;
    moves = moves_q;
    sw    = (room_q == STASH);
    win   = (room_q == VAULT);
    dead  = (room_q == GRAVE);
  end

endmodule

// File: tb/tb_adventure_room_fsm.sv
// Self-checking bench: three configurations of the room controller against a map-table model.
module tb_adventure_room_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       n, s, e, w, v;

  // a: default; b: budget of 3 moves; c: 2-bit saturating counter
  logic       sw_a, win_a, dead_a;
  logic [2:0] room_a;
  logic [7:0] moves_a;
  logic       sw_b, win_b, dead_b;
  logic [2:0] room_b;
  logic [7:0] moves_b;
  logic       sw_c, win_c, dead_c;
  logic [2:0] room_c;
  logic [1:0] moves_c;

  int checks = 0;
  int errors = 0;

  // Reference model state per configuration
  int m_room [3];
  int m_moves[3];
  bit m_armed[3];
  int mw [3] = '{8, 8, 2};
  int mx [3] = '{0, 3, 0};
  // Destination per [room][dir], rooms CAVE..STASH, dirs N,S,E,W (4 = DEN)
  int map_t [4][4] = '{'{0, 0, 1, 0}, '{1, 2, 1, 0}, '{1, 2, 4, 3}, '{3, 3, 2, 3}};

  always #5 clk = ~clk;

  adventure_room_fsm #(.MOVE_W(8), .MAX_MOVES(0)) dut_a (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
    .sw(sw_a), .win(win_a), .dead(dead_a), .room(room_a), .moves(moves_a)
  );
  adventure_room_fsm #(.MOVE_W(8), .MAX_MOVES(3)) dut_b (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
    .sw(sw_b), .win(win_b), .dead(dead_b), .room(room_b), .moves(moves_b)
  );
  adventure_room_fsm #(.MOVE_W(2), .MAX_MOVES(0)) dut_c (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
    .sw(sw_c), .win(win_c), .dead(dead_c), .room(room_c), .moves(moves_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_room[i]  = 0;
      m_moves[i] = 0;
      m_armed[i] = 1'b0;
    end
  endfunction

  // One clock of the game rules for every configuration.
  function automatic void model_step(input bit bn, input bit bs, input bit be, input bit bw, input bit bv);
    int cnt, d, nr, sat;
    bit acc;
    cnt = bn + bs + be + bw;
    d   = bn ? 0 : (bs ? 1 : (be ? 2 : 3));
    for (int i = 0; i < 3; i++) begin
      acc = m_armed[i] && (cnt == 1);
      nr  = m_room[i];
      sat = (1 << mw[i]) - 1;
      if (m_room[i] == 4) begin
        nr = bv ? 5 : 6;
      end else if (m_room[i] < 4) begin
        if (mx[i] != 0 && m_moves[i] == mx[i]) begin
          nr = 6;
        end else if (acc && map_t[m_room[i]][d] != m_room[i]) begin
          nr = map_t[m_room[i]][d];
          if (m_moves[i] < sat) m_moves[i] = m_moves[i] + 1;
        end
      end
      m_armed[i] = acc ? 1'b0 : ((cnt == 0) ? 1'b1 : m_armed[i]);
      m_room[i]  = nr;
    end
  endfunction

  task automatic check_all(input string ph);
    check($sformatf("%s a.room", ph), room_a, m_room[0]);
    check($sformatf("%s a.moves", ph), moves_a, m_moves[0]);
    check($sformatf("%s a.sw", ph), sw_a, m_room[0] == 3);
    check($sformatf("%s a.win", ph), win_a, m_room[0] == 5);
    check($sformatf("%s a.dead", ph), dead_a, m_room[0] == 6);
    check($sformatf("%s b.room", ph), room_b, m_room[1]);
    check($sformatf("%s b.moves", ph), moves_b, m_moves[1]);
    check($sformatf("%s b.sw", ph), sw_b, m_room[1] == 3);
    check($sformatf("%s b.win", ph), win_b, m_room[1] == 5);
    check($sformatf("%s b.dead", ph), dead_b, m_room[1] == 6);
    check($sformatf("%s c.room", ph), room_c, m_room[2]);
    check($sformatf("%s c.moves", ph), moves_c, m_moves[2]);
    check($sformatf("%s c.sw", ph), sw_c, m_room[2] == 3);
    check($sformatf("%s c.win", ph), win_c, m_room[2] == 5);
    check($sformatf("%s c.dead", ph), dead_c, m_room[2] == 6);
  endtask

  // Drive buttons just after a falling edge, advance one clock, check on the next falling edge.
  task automatic step(input string ph, input logic bn, input logic bs, input logic be, input logic bw);
    n = bn; s = bs; e = be; w = bw;
    @(posedge clk);
    model_step(bn, bs, be, bw, v);
    @(negedge clk);
    check_all(ph);
  endtask

  // Single button press followed by a release cycle.
  task automatic press(input string ph, input logic bn, input logic bs, input logic be, input logic bw);
    step(ph, bn, bs, be, bw);
    step(ph, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle with buttons left as they are; released on a falling edge.
  task automatic do_reset(input string ph);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all({ph, " async"});
    check({ph, " async a.room"}, room_a, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1;
    n = 0; s = 0; e = 0; w = 0; v = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all("reset_state");
    check("reset a.room", room_a, 0);
    check("reset a.moves", moves_a, 0);

    // Win path
    step("win", 0, 0, 0, 0);
    press("win", 0, 0, 1, 0);
    press("win", 0, 1, 0, 0);
    press("win", 0, 0, 0, 1);
    check("win stash room", room_a, 3);
    check("win stash sw", sw_a, 1);
    v = 1;
    press("win", 0, 0, 1, 0);
    check("win river sw", sw_a, 0);
    step("win", 0, 0, 1, 0);
    check("win den room", room_a, 4);
    step("win", 0, 0, 0, 0);
    check("win vault room", room_a, 5);
    check("win flag", win_a, 1);
    check("win dead", dead_a, 0);
    check("win moves", moves_a, 5);
    press("win_frozen", 0, 0, 0, 1);
    press("win_frozen", 1, 0, 0, 0);
    check("win frozen room", room_a, 5);

    // Lose path
    do_reset("lose");
    v = 0;
    step("lose", 0, 0, 0, 0);
    press("lose", 0, 0, 1, 0);
    press("lose", 0, 1, 0, 0);
    step("lose", 0, 0, 1, 0);
    check("lose den room", room_a, 4);
    step("lose", 0, 0, 0, 0);
    check("lose grave room", room_a, 6);
    check("lose dead", dead_a, 1);
    check("lose moves", moves_a, 3);
    press("lose_frozen", 1, 0, 0, 0);
    press("lose_frozen", 0, 0, 0, 1);
    check("lose frozen moves", moves_a, 3);

    // Held and multi-button
    do_reset("held");
    step("held", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("held", 0, 0, 1, 0);
    check("held room", room_a, 1);
    check("held moves", moves_a, 1);
    step("held", 0, 0, 0, 0);
    step("multi", 1, 1, 0, 0);
    check("multi room", room_a, 1);
    step("multi", 0, 0, 0, 0);

    // Invalid direction, then a change of button without release
    do_reset("inval");
    step("inval", 0, 0, 0, 0);
    step("inval", 1, 0, 0, 0);
    check("inval room", room_a, 0);
    step("inval", 0, 0, 1, 0);
    check("inval no_rearm room", room_a, 0);
    step("inval", 0, 0, 0, 0);
    step("inval", 0, 0, 1, 0);
    check("inval rearmed room", room_a, 1);

    // Budget (b) and saturation (c)
    do_reset("budget");
    step("budget", 0, 0, 0, 0);
    press("budget", 0, 0, 1, 0);
    press("budget", 0, 0, 0, 1);
    step("budget", 0, 0, 1, 0);
    check("budget b.room", room_b, 1);
    check("budget b.moves", moves_b, 3);
    step("budget", 0, 0, 0, 0);
    check("budget b.dead", dead_b, 1);
    check("budget b.moves_after", moves_b, 3);
    press("sat", 0, 0, 0, 1);
    press("sat", 0, 0, 1, 0);
    check("sat c.moves", moves_c, 3);
    check("sat c.room", room_c, 1);

    // Reset mid-game in RIVER with e held
    do_reset("mid");
    step("mid", 0, 0, 0, 0);
    press("mid", 0, 0, 1, 0);
    step("mid", 0, 1, 0, 0);
    step("mid", 0, 0, 1, 0);
    check("mid river room", room_a, 2);
    do_reset("mid");
    for (int i = 0; i < 3; i++) step("mid_held", 0, 0, 1, 0);
    check("mid held room", room_a, 0);
    step("mid", 0, 0, 0, 0);
    step("mid", 0, 0, 1, 0);
    check("mid repress room", room_a, 1);

    // Randomized play
    for (int k = 0; k < 600; k++) begin
      v = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rand");
        step("rand", 0, 0, 0, 0);
      end else if (r <= 3) begin
        step("rand", 0, 0, 0, 0);
      end else if (r <= 7) begin
        case ($urandom_range(0, 3))
          0: step("rand", 1, 0, 0, 0);
          1: step("rand", 0, 1, 0, 0);
          2: step("rand", 0, 0, 1, 0);
          default: step("rand", 0, 0, 0, 1);
        endcase
      end else begin
        r = $urandom_range(0, 15);
        step("rand", r[0], r[1], r[2], r[3]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adventure_room_fsm.md
Name: adventure_room_fsm

Overview:
- Room-navigation controller for the adventure game; the counterpart of the sword-possession tracker.
- Drives the sword-room indication `sw` into the tracker and consumes the tracker's vorpal-sword flag `v` to resolve the dragon encounter.
- Qualifies player direction buttons, walks the map, counts moves and reports win/death status for display.

Parameters:
- MOVE_W, 8, width of the move counter.
- MAX_MOVES, 0, move budget. 0 disables it. Otherwise, reaching MAX_MOVES outside a terminal room forces death.

Ports:
- clk  input  1  clock
- reset  input  1  async active-high reset
- n  input  1  north button, level
- s  input  1  south button, level
- e  input  1  east button, level
- w  input  1  west button, level
- v  input  1  vorpal sword held, from sword tracker
- sw  output  1  player is in Secret Sword Stash (sword-found pulse/level to tracker)
- win  output  1  player is in Victory Vault
- dead  output  1  player is in Grievous Graveyard
- room  output  3  current room code
- moves  output  MOVE_W  accepted-move count

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values: room=CAVE(0), sw=0, win=0, dead=0, moves=0, armed=0.
- Room codes: CAVE=0, TUNNEL=1, RIVER=2, STASH=3, DEN=4, VAULT=5, GRAVE=6. Code 7 is illegal and goes to CAVE on the next clock.
- Moore outputs, decoded from the room register:
  - sw = (room==STASH)
  - win = (room==VAULT)
  - dead = (room==GRAVE)
- Direction qualification:
  - `armed` register is set at the clock edge of any cycle with n=s=e=w=0.
  - A move is accepted in a cycle where armed=1 and exactly one of n,s,e,w is 1.
  - Acceptance clears armed at that edge.
  - Multiple directions asserted at once are ignored; armed is unchanged.
  - A button held across cycles yields exactly one move.
- Map transitions (accepted move only):
  - CAVE: e→TUNNEL
  - TUNNEL: w→CAVE, s→RIVER
  - RIVER: n→TUNNEL, w→STASH, e→DEN
  - STASH: e→RIVER
  - Any other direction in a room: the move is accepted (armed cleared), the room is unchanged and moves is not incremented.
- DEN: transient, lasts exactly one cycle. Next room is VAULT if v=1 in the DEN cycle, else GRAVE. Direction inputs are ignored in DEN; armed may still set.
- VAULT and GRAVE are terminal: all inputs are ignored and moves is frozen until reset.
- Move counter:
  - Increments by 1 on each accepted move that changes the room.
  - Saturates at 2^MOVE_W-1.
  - The DEN→VAULT/GRAVE step is not counted.
- Move budget (MAX_MOVES≠0): in a non-terminal, non-DEN room with moves==MAX_MOVES, next room is GRAVE. This overrides any direction input in that cycle.
- Latency: room updates on the clock edge after the accepting cycle. Outputs follow combinationally from the room register.
- Reset mid-game: room returns to CAVE and moves to 0 immediately. armed=0, so a button held through reset release is not taken as a move.

Decomposition:
- Package adventure_pkg:
  - room_t enum (3-bit, codes above).
  - Direction index constants DIR_N/S/E/W.
  - Constant ROOM_ILLEGAL=7.
- One sub-module, dir_qualify:
  - Inputs: clk, reset, n, s, e, w.
  - Outputs: one-hot 4-bit `dir` valid for one cycle, and `accept`.
  - Contains the armed register and the exactly-one check.
- Top level holds the room register, next-room logic, counter and output decode.

Test Plan:
- Win path: after reset, pulse e, s, w (enter STASH, sw=1), drive tracker v=1, then e, e with idle between → room goes 1,2,3,2,4,5. win=1, dead=0, moves=5, sw=1 only in STASH.
- Lose path: e, s, e with v=0 → DEN for one cycle, then GRAVE. dead=1, moves=3. Further buttons leave room=6 and moves=3.
- Held/multi-button: hold e for 10 cycles from CAVE → exactly one move (room=1, moves=1). Assert n+s together from TUNNEL → no change.
- Invalid direction: n in CAVE → room stays 0, moves 0. The next e is only taken after an all-idle cycle.
- Budget: MAX_MOVES=3; bounce e, w, e → on reaching moves=3 in TUNNEL, next clock room=GRAVE, dead=1.
- Reset mid-game: assert reset asynchronously while in RIVER with e held → room=0, moves=0 at once. After release with e still held, no move until e released and re-pressed.
